// File: rtl/peripheral_bfm_memory_bb_if.sv
// peripheral_bfm_memory_bb_if: Wishbone B3 bus bundle between the transactor master and the memory slave
interface peripheral_bfm_memory_bb_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic [AW-1:0] wb_adr_i;
  logic [DW-1:0] wb_dat_i;
  logic [DW/8-1:0] wb_sel_i;
  logic wb_we_i;
  logic wb_cyc_i;
  logic wb_stb_i;
  logic [2:0] wb_cti_i;
  logic [1:0] wb_bte_i;
  logic [DW-1:0] wb_dat_o;
  logic wb_ack_o;
  logic wb_err_o;
  logic wb_rty_o;
  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
  modport slave (
    input wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/peripheral_bfm_memory_bb.sv
// peripheral_bfm_memory_bb: Wishbone B3 slave RAM with wait states and bursts; PERIPHERAL_BFM_MEMORY_ERR_EN enables out-of-range error response
module peripheral_bfm_memory_bb #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter logic [AW-1:0] MEM_BASE = '0,
  parameter int MEM_SIZE_BYTES = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic wb_clk_i,
  input logic wb_rst_i,
  peripheral_bfm_memory_bb_if.slave s
);
`ifdef PERIPHERAL_BFM_MEMORY_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int WORDS = MEM_SIZE_BYTES / 4;
  localparam int IW = $clog2(WORDS);
  localparam logic [AW-1:0] SIZE = AW'(MEM_SIZE_BYTES);
  localparam logic [AW-1:0] MASK = SIZE - AW'(1);
  typedef enum logic [1:0] {IDLE, WAIT, ACTIVE} state_t;
  state_t state;
  logic [DW-1:0] mem [WORDS];
  logic [AW-1:0] burst_adr, next_adr, lin_adr, tgt, off_b, off_t;
  logic [IW-1:0] idx_b, idx_t;
  logic [3:0] wcnt;
  logic [DW-1:0] dat_q, rd_val;
  logic ack_q, err_q, req, cont, go_on, bad, wr, resp, to_wait;
  // Beat address sequencing, range check and response decision for this edge
  always_comb begin
    req = s.wb_cyc_i & s.wb_stb_i;
    cont = s.wb_cti_i == 3'b001 || s.wb_cti_i == 3'b010;
    go_on = state == ACTIVE && req && cont && !err_q;
    off_b = burst_adr - MEM_BASE;
    idx_b = off_b[IW+1:2];
    lin_adr = ERR_EN ? burst_adr + AW'(4) : MEM_BASE + ((off_b + AW'(4)) & MASK);
    next_adr = s.wb_cti_i == 3'b001 ? burst_adr :
               s.wb_bte_i == 2'b00 ? lin_adr :
               s.wb_bte_i == 2'b01 ? {burst_adr[AW-1:4], burst_adr[3:2] + 2'd1, burst_adr[1:0]} :
               s.wb_bte_i == 2'b10 ? {burst_adr[AW-1:5], burst_adr[4:2] + 3'd1, burst_adr[1:0]} :
                                     {burst_adr[AW-1:6], burst_adr[5:2] + 4'd1, burst_adr[1:0]};
    tgt = state == IDLE ? s.wb_adr_i : state == ACTIVE ? next_adr : burst_adr;
    off_t = tgt - MEM_BASE;
    idx_t = off_t[IW+1:2];
    bad = ERR_EN && off_t >= SIZE;
    wr = state == ACTIVE && ack_q && req && s.wb_we_i && !wb_rst_i;
    resp = req && (state == IDLE ? WAIT_STATES == 0 : state == WAIT ? wcnt == 4'd1 : go_on && WAIT_STATES == 0);
    to_wait = WAIT_STATES != 0 && ((state == IDLE && req) || go_on);
    rd_val = mem[idx_t];
    for (int b = 0; b < DW / 8; b++)
      rd_val[8*b +: 8] = wr && s.wb_sel_i[b] && idx_b == idx_t ? s.wb_dat_i[8*b +: 8] : mem[idx_t][8*b +: 8];
  end
  // Bus FSM: ACTIVE means a registered ack or err is on the bus this cycle
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
      wcnt <= '0;
    end else begin
      state <= resp ? ACTIVE : to_wait || (state == WAIT && req) ? WAIT : IDLE;
      ack_q <= resp && !bad;
      err_q <= resp && bad;
      wcnt <= to_wait ? 4'(WAIT_STATES) : wcnt - 4'd1;
      if (resp) dat_q <= bad ? '0 : rd_val;
    end
    burst_adr <= tgt;
  end
  // Byte-lane write at the edge that completes an acked write beat
  always_ff @(posedge wb_clk_i)
    if (wr)
      for (int b = 0; b < DW / 8; b++)
        if (s.wb_sel_i[b]) mem[idx_b][8*b +: 8] <= s.wb_dat_i[8*b +: 8];
  assign s.wb_dat_o = dat_q;
  assign s.wb_ack_o = ack_q;
  assign s.wb_err_o = err_q;
  assign s.wb_rty_o = 1'b0;
endmodule

// File: tb/tb_peripheral_bfm_memory_bb.sv
// tb_peripheral_bfm_memory_bb: directed checks of the Wishbone memory model with 0 and 2 wait states
module tb_peripheral_bfm_memory_bb;
`ifdef PERIPHERAL_BFM_MEMORY_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  typedef struct {
    logic we;
    logic [31:0] adr;
    logic [3:0] sel;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [31:0] adr, dat, rd;
  logic [3:0] sel;
  logic [2:0] cti;
  logic [1:0] bte;
  logic we, cyc, stb, which, ack, err;
  logic [31:0] wd [8], rdv [8];
  int lat [8];
  logic rack [8], rerr [8];
  logic after_ack;
  int n_cmp = 0, n_bad = 0;
  peripheral_bfm_memory_bb_if #(.AW(32), .DW(32)) if0 ();
  peripheral_bfm_memory_bb_if #(.AW(32), .DW(32)) if2 ();
  assign if0.wb_adr_i = adr;
  assign if0.wb_dat_i = dat;
  assign if0.wb_sel_i = sel;
  assign if0.wb_we_i = we;
  assign if0.wb_cti_i = cti;
  assign if0.wb_bte_i = bte;
  assign if0.wb_cyc_i = cyc & ~which;
  assign if0.wb_stb_i = stb & ~which;
  assign if2.wb_adr_i = adr;
  assign if2.wb_dat_i = dat;
  assign if2.wb_sel_i = sel;
  assign if2.wb_we_i = we;
  assign if2.wb_cti_i = cti;
  assign if2.wb_bte_i = bte;
  assign if2.wb_cyc_i = cyc & which;
  assign if2.wb_stb_i = stb & which;
  assign ack = which ? if2.wb_ack_o : if0.wb_ack_o;
  assign err = which ? if2.wb_err_o : if0.wb_err_o;
  assign rd = which ? if2.wb_dat_o : if0.wb_dat_o;
  peripheral_bfm_memory_bb #(.WAIT_STATES(0)) dut0 (.wb_clk_i(clk), .wb_rst_i(rst), .s(if0.slave));
  peripheral_bfm_memory_bb #(.WAIT_STATES(2)) dut2 (.wb_clk_i(clk), .wb_rst_i(rst), .s(if2.slave));
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask
  task automatic wait_resp(output int t, output bit to);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(ack || err) && t < 50);
    to = !(ack || err);
  endtask
  // lat[k] is edges from stb (first beat) or from the previous ack (later beats)
  task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [2:0] ct,
                      input logic [1:0] bt, input int n, output bit to);
    int t;
    @(posedge clk);
    #1;
    adr = a; we = w; sel = s; bte = bt; cyc = 1'b1; stb = 1'b1; to = 1'b0;
    for (int k = 0; k < n && !to; k++) begin
      dat = wd[k];
      cti = (k == n - 1 && ct != 3'b000) ? 3'b111 : ct;
      wait_resp(t, to);
      lat[k] = k == 0 ? t - 1 : t;
      rdv[k] = rd;
      rack[k] = ack;
      rerr[k] = err;
      @(posedge clk);
      #1;
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    after_ack = ack || err;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bit to;
    int t;
    vec_t tbl [12];
    tbl[0] = '{1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0};
    tbl[1] = '{1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 32'h10, 4'h1, 32'h000000AA, 32'h0};
    tbl[3] = '{1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEAA};
    tbl[4] = '{1'b1, 32'h00, 4'hF, 32'hCAFEF00D, 32'h0};
    tbl[5] = '{1'b1, 32'h3FC, 4'hF, 32'h11223344, 32'h0};
    tbl[6] = '{1'b1, 32'h3FC, 4'h6, 32'hAABBCCDD, 32'h0};
    tbl[7] = '{1'b0, 32'h3FC, 4'hF, 32'h0, 32'h11BBCC44};
    tbl[8] = '{1'b0, 32'h00, 4'hF, 32'h0, 32'hCAFEF00D};
    tbl[9] = '{1'b1, 32'h10, 4'h8, 32'h55000000, 32'h0};
    tbl[10] = '{1'b0, 32'h13, 4'hF, 32'h0, 32'h55ADBEAA};
    tbl[11] = '{1'b0, 32'h3FD, 4'hF, 32'h0, 32'h11BBCC44};
    adr = '0; dat = '0; sel = '0; cti = '0; bte = '0;
    we = 1'b0; cyc = 1'b0; stb = 1'b0; which = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack0", if0.wb_ack_o, 0);
    chk("rst_err0", if0.wb_err_o, 0);
    chk("rst_dat0", if0.wb_dat_o, 0);
    chk("rst_ack2", if2.wb_ack_o, 0);
    chk("rst_dat2", if2.wb_dat_o, 0);
    chk("rty0", if0.wb_rty_o, 0);
    rst = 1'b0;
    foreach (tbl[i]) begin
      wd[0] = tbl[i].dat;
      xfer(tbl[i].we, tbl[i].adr, tbl[i].sel, 3'b000, 2'b00, 1, to);
      chk($sformatf("v%0d_timeout", i), to, 0);
      chk($sformatf("v%0d_lat", i), lat[0], 1);
      chk($sformatf("v%0d_gap", i), after_ack, 0);
      if (!tbl[i].we) chk($sformatf("v%0d_rdata", i), rdv[0], tbl[i].exp);
    end
    for (int k = 0; k < 4; k++) wd[k] = k + 1;
    xfer(1'b1, 32'h20, 4'hF, 3'b010, 2'b00, 4, to);
    chk("lin_wr_timeout", to, 0);
    for (int k = 0; k < 4; k++) chk($sformatf("lin_wr_lat%0d", k), lat[k], 1);
    chk("lin_wr_end", after_ack, 0);
    xfer(1'b0, 32'h20, 4'hF, 3'b010, 2'b00, 4, to);
    for (int k = 0; k < 4; k++) chk($sformatf("lin_rd%0d", k), rdv[k], k + 1);
    for (int k = 0; k < 4; k++) wd[k] = 32'hA0A0A0A0 + k * 32'h01010101;
    xfer(1'b1, 32'h30, 4'hF, 3'b010, 2'b00, 4, to);
    xfer(1'b0, 32'h38, 4'hF, 3'b010, 2'b01, 4, to);
    chk("wrap4_timeout", to, 0);
    for (int k = 0; k < 4; k++) chk($sformatf("wrap4_rd%0d", k), rdv[k], 32'hA0A0A0A0 + ((k + 2) % 4) * 32'h01010101);
    xfer(1'b0, 32'h10, 4'hF, 3'b001, 2'b00, 3, to);
    for (int k = 0; k < 3; k++) chk($sformatf("const_rd%0d", k), rdv[k], 32'h55ADBEAA);
    xfer(1'b0, 32'h3FC, 4'hF, 3'b010, 2'b00, 2, to);
    chk("end_rd0", rdv[0], 32'h11BBCC44);
    chk("end_rd1", rdv[1], ERR_EN ? 32'h0 : 32'hCAFEF00D);
    chk("end_err1", rerr[1], ERR_EN);
    chk("end_gap", after_ack, 0);
    wd[0] = 32'h99999999;
    xfer(1'b1, 32'h400, 4'hF, 3'b000, 2'b00, 1, to);
    chk("oor_wr_err", rerr[0], ERR_EN);
    chk("oor_wr_ack", rack[0], !ERR_EN);
    xfer(1'b0, 32'h400, 4'hF, 3'b000, 2'b00, 1, to);
    chk("oor_rd_err", rerr[0], ERR_EN);
    chk("oor_rd_ack", rack[0], !ERR_EN);
    chk("oor_rd_data", rdv[0], ERR_EN ? 32'h0 : 32'h99999999);
    xfer(1'b0, 32'h0, 4'hF, 3'b000, 2'b00, 1, to);
    chk("oor_word0", rdv[0], ERR_EN ? 32'hCAFEF00D : 32'h99999999);
    which = 1'b1;
    for (int k = 0; k < 4; k++) wd[k] = 32'h11111111 * (k + 1);
    xfer(1'b1, 32'h80, 4'hF, 3'b010, 2'b00, 4, to);
    chk("ws_wr_timeout", to, 0);
    for (int k = 0; k < 4; k++) chk($sformatf("ws_wr_lat%0d", k), lat[k], 3);
    xfer(1'b0, 32'h84, 4'hF, 3'b000, 2'b00, 1, to);
    chk("ws_rd_lat", lat[0], 3);
    chk("ws_rd_data", rdv[0], 32'h22222222);
    chk("ws_rd_gap", after_ack, 0);
    @(posedge clk);
    #1;
    adr = 32'h80; we = 1'b1; sel = 4'hF; cti = 3'b010; bte = 2'b00;
    dat = 32'h5A5A5A5A; cyc = 1'b1; stb = 1'b1;
    wait_resp(t, to);
    chk("mid_b1_timeout", to, 0);
    @(posedge clk);
    #1;
    dat = 32'h6B6B6B6B;
    wait_resp(t, to);
    chk("mid_b2_timeout", to, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_err", err, 0);
    xfer(1'b0, 32'h80, 4'hF, 3'b010, 2'b00, 4, to);
    chk("mid_rd_timeout", to, 0);
    chk("mid_rd_lat0", lat[0], 3);
    chk("mid_rd0", rdv[0], 32'h5A5A5A5A);
    chk("mid_rd1", rdv[1], 32'h22222222);
    chk("mid_rd2", rdv[2], 32'h33333333);
    chk("mid_rd3", rdv[3], 32'h44444444);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
